// File: rtl/idm_pulse_stim_gen.sv
// Programmable pulse-train source driving the delay-chain input: count, high/low widths and polarity.
// Define STIM_RAND_EN to add the jitter_mask port and LFSR-driven rest-phase jitter.
module idm_pulse_stim_gen #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] high_cycles,
   input  logic [CNT_W-1:0] low_cycles,
   input  logic [NUM_W-1:0] num_pulses,
   input  logic             init_level,
`ifdef STIM_RAND_EN
   input  logic [CNT_W-1:0] jitter_mask,
`endif
   output logic             stim_out,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] pulse_idx
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_REST} state_t;

   localparam logic [CNT_W:0]   CNT_ONE = (CNT_W+1)'(1);
   localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

   // Phase length with a programmed 0 treated as 1; one extra bit so nothing wraps.
   function automatic logic [CNT_W:0] len_of(input logic [CNT_W-1:0] v);
      return {1'b0, v} + ((v == '0) ? CNT_ONE : '0);
   endfunction

   state_t           state, state_d;
   logic [CNT_W:0]   cnt, cnt_d;
   logic [CNT_W-1:0] high_s, high_d;
   logic [CNT_W-1:0] low_s, low_d;
   logic [NUM_W-1:0] num_s, num_d;
   logic             init_s, init_d;
   logic             stim_d, busy_d, done_d;
   logic [NUM_W-1:0] idx_d, idx_inc;
   logic [CNT_W:0]   rest_len;
   logic             rest_entry;

   assign idx_inc    = pulse_idx + NUM_ONE;
   assign rest_entry = (state == S_ACTIVE) && (cnt == '0);

`ifdef STIM_RAND_EN
   localparam logic [CNT_W+1:0] REST_MAX = {2'b01, {CNT_W{1'b0}}};

   logic [15:0]      lfsr;
   logic [CNT_W+1:0] rest_sum;

   // The current LFSR value sizes this rest; the register steps on the same edge.
   assign rest_sum = {1'b0, len_of(low_s)} + {2'b00, lfsr[CNT_W-1:0] & jitter_mask};
   assign rest_len = (rest_sum > REST_MAX) ? REST_MAX[CNT_W:0] : rest_sum[CNT_W:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr <= 16'hACE1;
      else if (rest_entry)
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end
`else
   assign rest_len = len_of(low_s);
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d = state;
      cnt_d   = cnt;
      high_d  = high_s;
      low_d   = low_s;
      num_d   = num_s;
      init_d  = init_s;
      stim_d  = stim_out;
      busy_d  = busy;
      done_d  = 1'b0;
      idx_d   = pulse_idx;

      unique case (state)
         S_IDLE: begin
            stim_d = init_level;
            if (start) begin
               high_d = high_cycles;
               low_d  = low_cycles;
               num_d  = num_pulses;
               init_d = init_level;
               idx_d  = '0;
               if (num_pulses == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_ACTIVE;
                  stim_d  = ~init_level;
                  busy_d  = 1'b1;
                  cnt_d   = len_of(high_cycles) - CNT_ONE;
               end
            end
         end

         S_ACTIVE: begin
            if (cnt == '0) begin
               state_d = S_REST;
               stim_d  = init_s;
               cnt_d   = rest_len - CNT_ONE;
            end else begin
               cnt_d = cnt - CNT_ONE;
            end
         end

         S_REST: begin
            if (cnt == '0) begin
               idx_d = idx_inc;
               if (idx_inc == num_s) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ACTIVE;
                  stim_d  = ~init_s;
                  cnt_d   = len_of(high_s) - CNT_ONE;
               end
            end else begin
               cnt_d = cnt - CNT_ONE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Everything, shadows included, returns to a known state so an abandoned train leaves no residue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         high_s    <= '0;
         low_s     <= '0;
         num_s     <= '0;
         init_s    <= 1'b0;
         stim_out  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pulse_idx <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state     <= state_d;
         cnt       <= cnt_d;
         high_s    <= high_d;
         low_s     <= low_d;
         num_s     <= num_d;
         init_s    <= init_d;
         stim_out  <= stim_d;
         busy      <= busy_d;
         done      <= done_d;
         pulse_idx <= idx_d;
      end
   end

endmodule
